// File: rtl/coordinated_move_fifo.sv
// Assembles multi-word coordinated-move messages from SPI words and queues complete
// moves in a first-word-fall-through FIFO consumed by the DDA timers via valid/ready.
module coordinated_move_fifo #(
  parameter int         MOTOR_COUNT = 1,
  parameter int         DEPTH_BITS  = 2,
  parameter logic [7:0] CMD_STEP    = 8'h01,
  parameter logic [7:0] CMD_FLUSH   = 8'h0F
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       word_valid,
  input  logic [63:0]                word_data,
  input  logic                       frame_abort,
  input  logic                       move_ready,
  output logic                       move_valid,
  output logic [MOTOR_COUNT-1:0]     move_dir,
  output logic [63:0]                move_duration,
  output logic [64*MOTOR_COUNT-1:0]  move_increment,
  output logic [64*MOTOR_COUNT-1:0]  move_incinc,
  output logic [DEPTH_BITS:0]        fifo_count,
  output logic                       fifo_full,
  output logic                       busy,
  output logic                       overflow,
  output logic [63:0]                reply_data
);

  localparam int         DEPTH       = 1 << DEPTH_BITS;
  localparam int         DW          = 64 * MOTOR_COUNT;
  localparam logic [2:0] LAST_AXIS   = 3'(MOTOR_COUNT - 1);
  localparam logic [4:0] DISCARD_LEN = 5'(2 * MOTOR_COUNT + 1);

  typedef enum logic [2:0] {IDLE, DUR, INC, INCINC, DISCARD} state_t;

  state_t                state_reg, state_next;
  logic [2:0]            axis_reg, axis_next;
  logic [4:0]            skip_reg, skip_next;
  logic                  word_take;
  logic                  header_take;
  logic                  step_start;
  logic                  commit;
  logic                  flush;
  logic                  overflow_set;
  logic                  pop;

  logic [MOTOR_COUNT-1:0] dir_reg;
  logic [63:0]            dur_reg;
  logic [DW-1:0]          inc_stage;
  logic [DW-1:0]          incinc_stage;
  logic [DW-1:0]          commit_incinc;

  logic [DEPTH_BITS-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_BITS:0]    count_reg;
  logic                   overflow_reg;
  logic [63:0]            reply_reg;

  logic [MOTOR_COUNT-1:0] dir_mem    [DEPTH];
  logic [63:0]            dur_mem    [DEPTH];
  logic [DW-1:0]          inc_mem    [DEPTH];
  logic [DW-1:0]          incinc_mem [DEPTH];

  assign word_take = word_valid && !frame_abort;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      axis_reg  <= '0;
      skip_reg  <= '0;
    end else begin
      state_reg <= state_next;
      axis_reg  <= axis_next;
      skip_reg  <= skip_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    axis_next    = axis_reg;
    skip_next    = skip_reg;
    header_take  = 1'b0;
    step_start   = 1'b0;
    commit       = 1'b0;
    flush        = 1'b0;
    overflow_set = 1'b0;
    if (frame_abort) begin
      state_next = IDLE;
      axis_next  = '0;
      skip_next  = '0;
    end else if (word_valid) begin
      case (state_reg)
        IDLE: begin
          header_take = 1'b1;
          if (word_data[63:56] == CMD_STEP) begin
            // Room is decided here; later pops cannot rescue a dropped move.
            if (fifo_full) begin
              state_next = DISCARD;
              skip_next  = DISCARD_LEN;
            end else begin
              step_start = 1'b1;
              state_next = DUR;
              axis_next  = '0;
            end
          end else if (word_data[63:56] == CMD_FLUSH) begin
            flush = 1'b1;
          end
        end
        DUR:    state_next = INC;
        INC:    state_next = INCINC;
        INCINC: begin
          if (axis_reg == LAST_AXIS) begin
            commit     = 1'b1;
            state_next = IDLE;
            axis_next  = '0;
          end else begin
            axis_next  = axis_reg + 3'd1;
            state_next = INC;
          end
        end
        DISCARD: begin
          if (skip_reg == 5'd1) begin
            overflow_set = 1'b1;
            state_next   = IDLE;
            skip_next    = '0;
          end else begin
            skip_next = skip_reg - 5'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      dir_reg <= '0;
      dur_reg <= '0;
    end else begin
      if (step_start)
        dir_reg <= word_data[MOTOR_COUNT-1:0];
      if (word_take && state_reg == DUR)
        dur_reg <= word_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MOTOR_COUNT; gi++) begin : g_axis
      logic [63:0] inc_reg, incinc_reg;
      always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
          inc_reg    <= '0;
          incinc_reg <= '0;
        end else if (word_take && axis_reg == 3'(gi)) begin
          if (state_reg == INC)
            inc_reg <= word_data;
          if (state_reg == INCINC)
            incinc_reg <= word_data;
        end
      end
      assign inc_stage[gi*64 +: 64]    = inc_reg;
      assign incinc_stage[gi*64 +: 64] = incinc_reg;
    end
  endgenerate

  // The last axis's incinc arrives on the commit cycle itself, so it bypasses staging.
  always_comb begin
    commit_incinc              = incinc_stage;
    commit_incinc[DW-1 -: 64]  = word_data;
  end

  always_ff @(posedge CLK) begin
    if (commit) begin
      dir_mem[wr_ptr_reg]    <= dir_reg;
      dur_mem[wr_ptr_reg]    <= dur_reg;
      inc_mem[wr_ptr_reg]    <= inc_stage;
      incinc_mem[wr_ptr_reg] <= commit_incinc;
    end
  end

  assign pop = move_valid && move_ready;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      reply_reg    <= '0;
    end else begin
      if (flush) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (commit)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (commit && !pop)
          count_reg <= count_reg + 1'b1;
        else if (pop && !commit)
          count_reg <= count_reg - 1'b1;
        if (overflow_set)
          overflow_reg <= 1'b1;
      end
      // Status snapshot is taken as it stood when the header arrived.
      if (header_take)
        reply_reg <= {48'b0, 8'(count_reg), 5'b0, move_valid, overflow_reg, fifo_full};
    end
  end

  assign move_valid     = (count_reg != '0);
  assign fifo_full      = (count_reg == (DEPTH_BITS + 1)'(DEPTH));
  assign fifo_count     = count_reg;
  assign overflow       = overflow_reg;
  assign busy           = (state_reg != IDLE);
  assign reply_data     = reply_reg;
  // Head fields read zero while empty so reset and drained states look identical.
  assign move_dir       = move_valid ? dir_mem[rd_ptr_reg]    : '0;
  assign move_duration  = move_valid ? dur_mem[rd_ptr_reg]    : '0;
  assign move_increment = move_valid ? inc_mem[rd_ptr_reg]    : '0;
  assign move_incinc    = move_valid ? incinc_mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_coordinated_move_fifo.sv
// Randomized and directed bench for coordinated_move_fifo (2 axes, depth 4) against a
// queue-based message model.
module tb_coordinated_move_fifo;

  localparam int MC    = 2;
  localparam int DB    = 2;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic          word_valid;
  logic [63:0]   word_data;
  logic          frame_abort;
  logic          move_ready;
  logic          move_valid;
  logic [MC-1:0] move_dir;
  logic [63:0]   move_duration;
  logic [127:0]  move_increment;
  logic [127:0]  move_incinc;
  logic [DB:0]   fifo_count;
  logic          fifo_full;
  logic          busy;
  logic          overflow;
  logic [63:0]   reply_data;

  coordinated_move_fifo #(.MOTOR_COUNT(MC), .DEPTH_BITS(DB)) dut (
    .CLK(CLK), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .frame_abort(frame_abort), .move_ready(move_ready), .move_valid(move_valid),
    .move_dir(move_dir), .move_duration(move_duration), .move_increment(move_increment),
    .move_incinc(move_incinc), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .busy(busy), .overflow(overflow), .reply_data(reply_data)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of whole moves plus the message being collected.
  logic [MC-1:0] q_dir[$];
  logic [63:0]   q_dur[$];
  logic [127:0]  q_inc[$];
  logic [127:0]  q_incinc[$];
  logic          m_ovf, m_active, m_drop;
  int            m_got;
  logic [MC-1:0] m_dir;
  logic [63:0]   m_dur, m_reply;
  logic [127:0]  m_inc, m_incinc;

  task automatic model_reset();
    q_dir.delete(); q_dur.delete(); q_inc.delete(); q_incinc.delete();
    m_ovf = 0; m_active = 0; m_drop = 0; m_got = 0; m_reply = '0;
  endtask

  task automatic model_step(input logic wv, input logic [63:0] d, input logic ab, input logic rdy);
    int n;
    int j;
    bit do_pop, do_push, do_flush;
    n = q_dur.size();
    do_pop = (n != 0) && rdy;
    do_push = 0;
    do_flush = 0;
    if (ab) begin
      m_active = 0;
    end else if (wv) begin
      if (!m_active) begin
        m_reply = {48'b0, 8'(n), 5'b0, n != 0, m_ovf, n == DEPTH};
        if (d[63:56] == 8'h01) begin
          m_active = 1; m_drop = (n == DEPTH); m_got = 0; m_dir = d[MC-1:0];
        end else if (d[63:56] == 8'h0F) begin
          do_flush = 1;
        end
      end else begin
        m_got++;
        if (m_got == 1) m_dur = d;
        else begin
          j = m_got - 2;
          if (j % 2 == 0) m_inc[(j/2)*64 +: 64] = d;
          else            m_incinc[(j/2)*64 +: 64] = d;
        end
        if (m_got == 1 + 2*MC) begin
          m_active = 0;
          if (m_drop) m_ovf = 1;
          else        do_push = 1;
        end
      end
    end
    if (do_flush) begin
      q_dir.delete(); q_dur.delete(); q_inc.delete(); q_incinc.delete();
      m_ovf = 0;
    end else begin
      if (do_pop) begin
        void'(q_dir.pop_front()); void'(q_dur.pop_front());
        void'(q_inc.pop_front()); void'(q_incinc.pop_front());
      end
      if (do_push) begin
        q_dir.push_back(m_dir); q_dur.push_back(m_dur);
        q_inc.push_back(m_inc); q_incinc.push_back(m_incinc);
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = q_dur.size();
    check("count", fifo_count, n);
    check("valid", move_valid, n != 0);
    check("full", fifo_full, n == DEPTH);
    check("overflow", overflow, m_ovf);
    check("busy", busy, m_active);
    check("reply", reply_data, m_reply);
    if (n != 0) begin
      check("dir", move_dir, q_dir[0]);
      check("duration", move_duration, q_dur[0]);
      check("increment", move_increment, q_inc[0]);
      check("incinc", move_incinc, q_incinc[0]);
    end else begin
      check("dir0", move_dir, 0);
      check("duration0", move_duration, 0);
      check("increment0", move_increment, 0);
      check("incinc0", move_incinc, 0);
    end
  endtask

  task automatic cycle(input logic wv, input logic [63:0] d, input logic ab, input logic rdy);
    word_valid = wv; word_data = d; frame_abort = ab; move_ready = rdy;
    @(posedge CLK);
    model_step(wv, d, ab, rdy);
    #1;
    check_all();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic send_move(input logic [MC-1:0] dir, input logic [63:0] dur, input logic last_ready);
    cycle(1, {8'h01, 54'd0, dir}, 0, 0);
    cycle(1, dur, 0, 0);
    for (int k = 0; k < 2*MC; k++)
      cycle(1, rnd64(), 0, (k == 2*MC-1) ? last_ready : 1'b0);
  endtask

  logic [63:0] hdr_flush;
  logic [63:0] hdr_other;

  initial begin
    hdr_flush = {8'h0F, 56'd0};
    hdr_other = {8'h00, 56'd0};
    reset = 1; word_valid = 0; word_data = '0; frame_abort = 0; move_ready = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_valid", move_valid, 0);
    check("rst_reply", reply_data, 0);
    check("rst_busy", busy, 0);
    reset = 0;

    // Two-axis message with known values.
    cycle(1, {8'h01, 54'd0, 2'b10}, 0, 0);
    cycle(1, 64'd100, 0, 0);
    cycle(1, 64'd5, 0, 0);
    cycle(1, 64'd0, 0, 0);
    cycle(1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
    cycle(1, 64'd1, 0, 0);
    check("mc_count", fifo_count, 1);
    check("mc_dur", move_duration, 100);
    check("mc_inc", move_increment, {64'hFFFF_FFFF_FFFF_FFFD, 64'd5});
    check("mc_incinc", move_incinc, {64'd1, 64'd0});
    check("mc_dir", move_dir, 2'b10);
    cycle(1, hdr_flush, 0, 0);

    // Overfill: fifth move is dropped.
    for (int i = 0; i < 5; i++) send_move(2'(i), 64'(200 + i), 0);
    check("of_count", fifo_count, 4);
    check("of_full", fifo_full, 1);
    check("of_flag", overflow, 1);
    cycle(1, hdr_other, 0, 0);
    check("of_reply_ovf", reply_data[1], 1);
    check("of_reply_cnt", reply_data[15:8], 4);
    check("of_head", move_duration, 200);

    // Drain to two, then flush.
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    check("drain_count", fifo_count, 2);
    cycle(1, hdr_flush, 0, 1);
    check("fl_count", fifo_count, 0);
    check("fl_valid", move_valid, 0);
    check("fl_ovf", overflow, 0);

    // Commit and pop in the same cycle with three queued.
    for (int i = 0; i < 3; i++) send_move(2'b01, 64'(1001 + i), 0);
    send_move(2'b11, 64'd1004, 1);
    check("cp_count", fifo_count, 3);
    check("cp_head", move_duration, 1002);
    cycle(1, hdr_flush, 0, 0);

    // Abort after the duration word (abort wins over a same-cycle word).
    cycle(1, {8'h01, 54'd0, 2'b11}, 0, 0);
    cycle(1, 64'd777, 0, 0);
    cycle(1, rnd64(), 1, 0);
    check("ab_busy", busy, 0);
    send_move(2'b10, 64'd888, 0);
    check("ab_count", fifo_count, 1);
    check("ab_dur", move_duration, 888);
    check("ab_dir", move_dir, 2'b10);
    cycle(1, hdr_flush, 0, 0);

    // Asynchronous reset in mid-message with two queued.
    send_move(2'b01, 64'd11, 0);
    send_move(2'b10, 64'd22, 0);
    cycle(1, {8'h01, 54'd0, 2'b11}, 0, 0);
    cycle(1, 64'd33, 0, 0);
    #1 reset = 1;
    #1;
    check("ar_count", fifo_count, 0);
    check("ar_valid", move_valid, 0);
    check("ar_dur", move_duration, 0);
    check("ar_inc", move_increment, 0);
    check("ar_busy", busy, 0);
    check("ar_ovf", overflow, 0);
    check("ar_reply", reply_data, 0);
    model_reset();
    #2 reset = 0;
    send_move(2'b01, 64'd44, 0);
    check("ar_after", fifo_count, 1);
    check("ar_after_dur", move_duration, 44);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      logic          wv, ab, rdy;
      logic [63:0]   d;
      int            r;
      wv  = 1'($urandom_range(0, 1));
      ab  = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 3) == 0);
      d   = rnd64();
      if (!m_active) begin
        r = $urandom_range(0, 9);
        if (r < 7)       d[63:56] = 8'h01;
        else if (r == 7) d[63:56] = 8'h0F;
        else             d[63:56] = 8'h5A;
      end
      cycle(wv, d, ab, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
